// File: rtl/typedef_pkg.sv
// Shared types for the ALU responder: operation encoding, FSM states, default width.
package typedef_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DONE
    } alu_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier; one multiplier bit per step.
module mul_shift_add
    import typedef_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEPS = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(STEPS) + 1;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   p0;
    logic [2*WIDTH-1:0]   p1;
    logic [WIDTH-1:0]     mplier;

    // The final step folds in the top two partial products so the full
    // product is ready on the edge where cnt reaches STEPS-1.
    always_comb begin
        p0       = mplier[0] ? mcand : '0;
        p1       = mplier[1] ? (mcand << 1) : '0;
        acc_next = acc + p0;
        product  = acc_next + p1;
        last     = (cnt == CW'(STEPS - 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            cnt    <= cnt + CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
        end
    end

endmodule

// File: rtl/alu_responder.sv
// ALU responder: single-cycle ADD/SUB/AND, iterative MUL, held result with done pulse.
module alu_responder
    import typedef_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MUL_STEPS = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  operation_t           operation,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    alu_state_t           state;
    logic [2*WIDTH-1:0]   quick;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic                 accept;
    logic                 mul_load;
    logic                 mul_last;

    always_comb begin
        ext_a    = {{WIDTH{1'b0}}, operand_a};
        ext_b    = {{WIDTH{1'b0}}, operand_b};
        accept   = start && (state != MUL_RUN);
        mul_load = accept && (operation == OP_MUL);
        quick    = '0;
        case (operation)
            OP_ADD:  quick = ext_a + ext_b;
            OP_SUB:  quick = ext_a - ext_b;
            OP_AND:  quick = ext_a & ext_b;
            default: quick = '0;
        endcase
    end

    mul_shift_add #(
        .WIDTH (WIDTH),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (state == MUL_RUN),
        .a       (operand_a),
        .b       (operand_b),
        .last    (mul_last),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (operation == OP_MUL) begin
                            state <= MUL_RUN;
                            busy  <= 1'b1;
                        end else begin
                            state  <= DONE;
                            result <= quick;
                            done   <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL_RUN: begin
                    if (mul_last) begin
                        state  <= DONE;
                        result <= product;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed scenarios plus randomized ops vs a reference model.
module tb_alu_responder;
    import typedef_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    operation_t  operation;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int passes = 0;

    alu_responder #(.WIDTH(8), .MUL_STEPS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operation (operation),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(operation_t op, int a, int b);
        case (op)
            OP_ADD:  return 16'(a + b);
            OP_SUB:  return 16'(a - b);
            OP_AND:  return 16'(a & b);
            default: return 16'(a * b);
        endcase
    endfunction

    function automatic int latency_of(operation_t op);
        return (op == OP_MUL) ? 8 : 1;
    endfunction

    // Pulses start for one edge; returns at the negedge of the cycle after acceptance.
    task automatic drive(input operation_t op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; operation = op; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; operation = OP_ADD; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result} !== 18'h0)
            $display("FAIL reset_state busy=%b done=%b result=%h required 0 0 0000", busy, done, result);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) $display("FAIL idle_done cycle %0d done=%b required 0", i, done);
            else passes++;
        end
    endtask

    task automatic test_single(input operation_t op, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] want);
        drive(op, a, b);
        checks++;
        if (done !== 1'b1 || result !== want)
            $display("FAIL single_%s done=%b result=%h required 1 %h", op.name(), done, result, want);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== want)
            $display("FAIL single_hold_%s done=%b result=%h required 0 %h", op.name(), done, result, want);
        else passes++;
    endtask

    task automatic test_mul_ignore_start;
        drive(OP_MUL, 8'd255, 8'd255);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL mul_busy cycle N+%0d busy=%b done=%b required 1 0", k, busy, done);
            else passes++;
            if (k == 3) begin
                start = 1'b1; operation = OP_ADD; operand_a = 8'd1; operand_b = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || result !== 16'hFE01)
            $display("FAIL mul_done busy=%b done=%b result=%h required 0 1 fe01", busy, done, result);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 16'hFE01)
            $display("FAIL mul_hold done=%b result=%h required 0 fe01", done, result);
        else passes++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1; operation = OP_ADD; operand_a = 8'd1; operand_b = 8'd2;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 16'd3)
            $display("FAIL b2b_add done=%b result=%h required 1 0003", done, result);
        else passes++;
        operation = OP_MUL; operand_a = 8'd12; operand_b = 8'd13;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (done !== 1'b0) begin
                checks++;
                $display("FAIL b2b_early_done cycle %0d done=%b required 0", k, done);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || result !== 16'h009C)
            $display("FAIL b2b_mul done=%b result=%h required 1 009c", done, result);
        else passes++;
    endtask

    task automatic test_reset_mid_mul;
        drive(OP_MUL, 8'd7, 8'd9);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result} !== 18'h0)
            $display("FAIL mid_mul_reset busy=%b done=%b result=%h required 0 0 0000", busy, done, result);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL mid_mul_quiet cycle %0d done=%b busy=%b required 0 0", i, done, busy);
            else passes++;
        end
        test_single(OP_ADD, 8'd1, 8'd1, 16'h0002);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            operation_t  op;
            logic [7:0]  a;
            logic [7:0]  b;
            logic [15:0] want;
            int          lat;
            op = operation_t'($urandom_range(3, 0));
            a = 8'($urandom);
            b = 8'($urandom);
            want = model(op, int'(a), int'(b));
            drive(op, a, b);
            lat = 1;
            while (done !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != latency_of(op) || result !== want || busy !== 1'b0)
                $display("FAIL random_%0d %s a=%0d b=%0d latency=%0d result=%h busy=%b required latency=%0d result=%h busy=0",
                         n, op.name(), a, b, lat, result, busy, latency_of(op), want);
            else passes++;
        end
    endtask

    initial begin
        test_reset;
        test_single(OP_ADD, 8'd200, 8'd100, 16'h012C);
        test_single(OP_SUB, 8'd3, 8'd5, 16'hFFFE);
        test_single(OP_AND, 8'hF0, 8'h3C, 16'h0030);
        test_single(OP_ADD, 8'd255, 8'd255, 16'h01FE);
        test_mul_ignore_start;
        test_back_to_back;
        test_reset_mid_mul;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
